// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared op codes, exception causes, widths and MEM-stage state encoding
package mem_access_pkg;

    localparam int RegWidth                = 32;
    localparam int ALUOpWidth              = 8;
    localparam int CSRAddrWidth            = 14;
    localparam int CauseWidth              = 7;
    localparam int FiveExceptionCauseWidth = 5 * CauseWidth;

    localparam logic [ALUOpWidth-1:0] ALU_NOP  = 8'h00;
    localparam logic [ALUOpWidth-1:0] ALU_LDB  = 8'h20;
    localparam logic [ALUOpWidth-1:0] ALU_LDH  = 8'h21;
    localparam logic [ALUOpWidth-1:0] ALU_LDW  = 8'h22;
    localparam logic [ALUOpWidth-1:0] ALU_LDBU = 8'h23;
    localparam logic [ALUOpWidth-1:0] ALU_LDHU = 8'h24;
    localparam logic [ALUOpWidth-1:0] ALU_STB  = 8'h25;
    localparam logic [ALUOpWidth-1:0] ALU_STH  = 8'h26;
    localparam logic [ALUOpWidth-1:0] ALU_STW  = 8'h27;

    localparam logic [CauseWidth-1:0] EXCEPTION_NOP = 7'h00;
    localparam logic [CauseWidth-1:0] EXCEPTION_ALE = 7'h09;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_ADDR = 3'd1,
        S_WAIT_DATA = 3'd2,
        S_DONE      = 3'd3,
        S_DRAIN     = 3'd4
    } mem_state_t;

endpackage

// File: rtl/mem_access_align.sv
// rtl/mem_access_align.sv - byte-lane strobes, store replication, ALE check and load extension
module mem_align
    import mem_access_pkg::*;
(
    input  logic [ALUOpWidth-1:0] aluop,
    input  logic [1:0]            addr_lo,
    input  logic [RegWidth-1:0]   store_data,
    input  logic [RegWidth-1:0]   load_word,
    output logic                  is_load,
    output logic                  is_store,
    output logic                  ale,
    output logic [3:0]            wstrb,
    output logic [RegWidth-1:0]   wdata,
    output logic [RegWidth-1:0]   load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = load_word[{addr_lo, 3'b000} +: 8];
    assign half_sel = load_word[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        ale       = 1'b0;
        wstrb     = 4'b0000;
        wdata     = '0;
        load_data = load_word;
        case (aluop)
            ALU_LDB: begin
                is_load   = 1'b1;
                load_data = {{24{byte_sel[7]}}, byte_sel};
            end
            ALU_LDBU: begin
                is_load   = 1'b1;
                load_data = {24'h000000, byte_sel};
            end
            ALU_LDH: begin
                is_load   = 1'b1;
                ale       = addr_lo[0];
                load_data = {{16{half_sel[15]}}, half_sel};
            end
            ALU_LDHU: begin
                is_load   = 1'b1;
                ale       = addr_lo[0];
                load_data = {16'h0000, half_sel};
            end
            ALU_LDW: begin
                is_load   = 1'b1;
                ale       = |addr_lo;
            end
            ALU_STB: begin
                is_store = 1'b1;
                wstrb    = 4'b0001 << addr_lo;
                wdata    = {4{store_data[7:0]}};
            end
            ALU_STH: begin
                is_store = 1'b1;
                ale      = addr_lo[0];
                wstrb    = 4'b0011 << {addr_lo[1], 1'b0};
                wdata    = {2{store_data[15:0]}};
            end
            ALU_STW: begin
                is_store = 1'b1;
                ale      = |addr_lo;
                wstrb    = 4'b1111;
                wdata    = store_data;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM stage: data-bus load/store sequencing, stall request and MEM/WB pass-through
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int CAUSE_W = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    exception_flush,
    input  logic                    pause_wb,

    input  logic [ADDR_W-1:0]       in_reg_write_data,
    input  logic [4:0]              in_reg_write_addr,
    input  logic                    in_reg_write_en,
    input  logic [ALUOpWidth-1:0]   in_aluop,
    input  logic [ADDR_W-1:0]       in_mem_addr,
    input  logic [ADDR_W-1:0]       in_store_data,
    input  logic                    in_csr_read_en,
    input  logic                    in_csr_write_en,
    input  logic [CSRAddrWidth-1:0] in_csr_addr,
    input  logic [ADDR_W-1:0]       in_csr_write_data,
    input  logic [ADDR_W-1:0]       in_csr_mask,
    input  logic [4:0]              in_is_exception,
    input  logic [5*CAUSE_W-1:0]    in_exception_cause,
    input  logic [ADDR_W-1:0]       in_pc,

    output logic                    data_req,
    output logic                    data_we,
    output logic [3:0]              data_wstrb,
    output logic [ADDR_W-1:0]       data_addr,
    output logic [ADDR_W-1:0]       data_wdata,
    input  logic                    data_addr_ok,
    input  logic                    data_data_ok,
    input  logic [ADDR_W-1:0]       data_rdata,

    output logic                    pause_request,

    output logic [ADDR_W-1:0]       out_reg_write_data,
    output logic [4:0]              out_reg_write_addr,
    output logic                    out_reg_write_en,
    output logic [ALUOpWidth-1:0]   out_aluop,
    output logic                    out_csr_read_en,
    output logic                    out_csr_write_en,
    output logic [CSRAddrWidth-1:0] out_csr_addr,
    output logic [ADDR_W-1:0]       out_csr_write_data,
    output logic [ADDR_W-1:0]       out_csr_mask,
    output logic [4:0]              out_is_exception,
    output logic [5*CAUSE_W-1:0]    out_exception_cause,
    output logic [ADDR_W-1:0]       out_pc
);

    mem_state_t          state, next_state;
    logic [ADDR_W-1:0]   load_buf;
    logic                is_load, is_store, ale, access, capture;
    logic [ADDR_W-1:0]   load_data;

    mem_align u_align (
        .aluop      (in_aluop),
        .addr_lo    (in_mem_addr[1:0]),
        .store_data (in_store_data),
        .load_word  (load_buf),
        .is_load    (is_load),
        .is_store   (is_store),
        .ale        (ale),
        .wstrb      (data_wstrb),
        .wdata      (data_wdata),
        .load_data  (load_data)
    );

    // Instructions already carrying an exception or misaligned never touch the bus.
    assign access    = (is_load || is_store) && (in_is_exception == 5'b00000) && !ale;
    assign data_we   = is_store;
    assign data_addr = {in_mem_addr[ADDR_W-1:2], 2'b00};
    assign capture   = (state == S_WAIT_DATA) && data_data_ok && !exception_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            load_buf <= '0;
        end else begin
            state <= next_state;
            if (capture) begin
                load_buf <= data_rdata;
            end
        end
    end

    always_comb begin
        next_state    = state;
        data_req      = 1'b0;
        pause_request = 1'b0;
        case (state)
            S_IDLE: begin
                if (access && !exception_flush) begin
                    data_req      = 1'b1;
                    pause_request = 1'b1;
                    next_state    = data_addr_ok ? S_WAIT_DATA : S_WAIT_ADDR;
                end
            end
            S_WAIT_ADDR: begin
                // Address not yet accepted, so a flush can still withdraw the request.
                if (exception_flush) begin
                    next_state = S_IDLE;
                end else begin
                    data_req      = 1'b1;
                    pause_request = 1'b1;
                    if (data_addr_ok) begin
                        next_state = S_WAIT_DATA;
                    end
                end
            end
            S_WAIT_DATA: begin
                pause_request = 1'b1;
                if (data_data_ok) begin
                    next_state = exception_flush ? S_IDLE : S_DONE;
                end else if (exception_flush) begin
                    next_state = S_DRAIN;
                end
            end
            S_DONE: begin
                if (exception_flush || !pause_wb) begin
                    next_state = S_IDLE;
                end
            end
            S_DRAIN: begin
                // The orphaned response is still due; hold any new access until it lands.
                pause_request = access;
                if (data_data_ok) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        out_reg_write_data  = in_reg_write_data;
        out_reg_write_en    = in_reg_write_en;
        out_is_exception    = in_is_exception;
        out_exception_cause = in_exception_cause;
        if ((state == S_DONE) && is_load) begin
            out_reg_write_data = load_data;
        end
        if (ale) begin
            out_reg_write_en                          = 1'b0;
            out_is_exception[3]                       = 1'b1;
            out_exception_cause[3*CAUSE_W +: CAUSE_W] = CAUSE_W'(EXCEPTION_ALE);
        end
    end

    assign out_reg_write_addr = in_reg_write_addr;
    assign out_aluop          = in_aluop;
    assign out_csr_read_en    = in_csr_read_en;
    assign out_csr_write_en   = in_csr_write_en;
    assign out_csr_addr       = in_csr_addr;
    assign out_csr_write_data = in_csr_write_data;
    assign out_csr_mask       = in_csr_mask;
    assign out_pc             = in_pc;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - directed scoreboard bench for the MEM stage
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        exception_flush, pause_wb;
    logic [31:0] in_reg_write_data;
    logic [4:0]  in_reg_write_addr;
    logic        in_reg_write_en;
    logic [7:0]  in_aluop;
    logic [31:0] in_mem_addr, in_store_data;
    logic        in_csr_read_en, in_csr_write_en;
    logic [13:0] in_csr_addr;
    logic [31:0] in_csr_write_data, in_csr_mask;
    logic [4:0]  in_is_exception;
    logic [34:0] in_exception_cause;
    logic [31:0] in_pc;
    logic        data_req, data_we;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        pause_request;
    logic [31:0] out_reg_write_data;
    logic [4:0]  out_reg_write_addr;
    logic        out_reg_write_en;
    logic [7:0]  out_aluop;
    logic        out_csr_read_en, out_csr_write_en;
    logic [13:0] out_csr_addr;
    logic [31:0] out_csr_write_data, out_csr_mask;
    logic [4:0]  out_is_exception;
    logic [34:0] out_exception_cause;
    logic [31:0] out_pc;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    mem_access dut (
        .clk(clk), .rst(rst), .exception_flush(exception_flush), .pause_wb(pause_wb),
        .in_reg_write_data(in_reg_write_data), .in_reg_write_addr(in_reg_write_addr),
        .in_reg_write_en(in_reg_write_en), .in_aluop(in_aluop), .in_mem_addr(in_mem_addr),
        .in_store_data(in_store_data), .in_csr_read_en(in_csr_read_en),
        .in_csr_write_en(in_csr_write_en), .in_csr_addr(in_csr_addr),
        .in_csr_write_data(in_csr_write_data), .in_csr_mask(in_csr_mask),
        .in_is_exception(in_is_exception), .in_exception_cause(in_exception_cause), .in_pc(in_pc),
        .data_req(data_req), .data_we(data_we), .data_wstrb(data_wstrb), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata), .pause_request(pause_request),
        .out_reg_write_data(out_reg_write_data), .out_reg_write_addr(out_reg_write_addr),
        .out_reg_write_en(out_reg_write_en), .out_aluop(out_aluop),
        .out_csr_read_en(out_csr_read_en), .out_csr_write_en(out_csr_write_en),
        .out_csr_addr(out_csr_addr), .out_csr_write_data(out_csr_write_data),
        .out_csr_mask(out_csr_mask), .out_is_exception(out_is_exception),
        .out_exception_cause(out_exception_cause), .out_pc(out_pc)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_sb(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed %0h expected <scoreboard empty>", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            check(tag, {32'h0, obs}, {32'h0, exp});
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] sd,
                          input logic we);
        in_aluop        = op;
        in_mem_addr     = addr;
        in_store_data   = sd;
        in_reg_write_en = we;
    endtask

    initial begin
        rst = 1'b1; exception_flush = 1'b0; pause_wb = 1'b0;
        in_reg_write_data = 32'h0; in_reg_write_addr = 5'd4; in_reg_write_en = 1'b0;
        in_aluop = ALU_NOP; in_mem_addr = 32'h0; in_store_data = 32'h0;
        in_csr_read_en = 1'b1; in_csr_write_en = 1'b0; in_csr_addr = 14'h0123;
        in_csr_write_data = 32'hCAFE_0001; in_csr_mask = 32'h0000_FFFF;
        in_is_exception = 5'b0; in_exception_cause = 35'h0; in_pc = 32'h1C00_0000;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;

        // Reset
        cyc(); cyc();
        @(negedge clk);
        check("reset_req", 64'(data_req), 64'h0);
        check("reset_pause", 64'(pause_request), 64'h0);
        check("reset_pc_pass", 64'(out_pc), 64'h1C00_0000);
        check("reset_csr_pass", 64'(out_csr_write_data), 64'hCAFE_0001);
        cyc(); rst = 1'b0;

        // Non-memory op passes through
        in_reg_write_data = 32'h0000_0055; in_reg_write_en = 1'b1;
        @(negedge clk);
        check("nop_data", 64'(out_reg_write_data), 64'h55);
        check("nop_pause", 64'(pause_request), 64'h0);
        check("nop_req", 64'(data_req), 64'h0);

        // LD_B, minimum latency
        cyc(); set_op(ALU_LDB, 32'h1C00_0003, 32'h0, 1'b1); data_addr_ok = 1'b1;
        exp_q.push_back(32'hFFFF_FF80);
        @(negedge clk);
        check("ldb_c0_req", 64'(data_req), 64'h1);
        check("ldb_c0_pause", 64'(pause_request), 64'h1);
        check("ldb_c0_addr", 64'(data_addr), 64'h1C00_0000);
        check("ldb_c0_wstrb", 64'(data_wstrb), 64'h0);
        check("ldb_c0_we", 64'(data_we), 64'h0);
        cyc(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h80FF_0000;
        @(negedge clk);
        check("ldb_c1_req", 64'(data_req), 64'h0);
        check("ldb_c1_pause", 64'(pause_request), 64'h1);
        cyc(); data_data_ok = 1'b0; data_rdata = 32'h0;
        @(negedge clk);
        check("ldb_c2_pause", 64'(pause_request), 64'h0);
        check_sb("ldb_result", out_reg_write_data);
        check("ldb_wen", 64'(out_reg_write_en), 64'h1);
        cyc(); set_op(ALU_NOP, 32'h0, 32'h0, 1'b0);

        // ST_H
        cyc(); set_op(ALU_STH, 32'h0000_0102, 32'h1234_ABCD, 1'b0); data_addr_ok = 1'b1;
        exp_q.push_back(32'hABCD_ABCD);
        @(negedge clk);
        check("sth_req", 64'(data_req), 64'h1);
        check("sth_we", 64'(data_we), 64'h1);
        check("sth_wstrb", 64'(data_wstrb), 64'hC);
        check_sb("sth_wdata", data_wdata);
        check("sth_addr", 64'(data_addr), 64'h100);
        check("sth_wen", 64'(out_reg_write_en), 64'h0);
        cyc(); data_addr_ok = 1'b0; data_data_ok = 1'b1;
        @(negedge clk);
        check("sth_c1_pause", 64'(pause_request), 64'h1);
        cyc(); data_data_ok = 1'b0;
        @(negedge clk);
        check("sth_c2_pause", 64'(pause_request), 64'h0);
        cyc(); set_op(ALU_NOP, 32'h0, 32'h0, 1'b0);

        // LD_W misaligned -> ALE
        cyc(); set_op(ALU_LDW, 32'h0000_0006, 32'h0, 1'b1);
        @(negedge clk);
        check("ale_req", 64'(data_req), 64'h0);
        check("ale_pause", 64'(pause_request), 64'h0);
        check("ale_flag", 64'(out_is_exception), 64'h08);
        check("ale_cause", 64'(out_exception_cause), 64'(EXCEPTION_ALE) << 21);
        check("ale_wen", 64'(out_reg_write_en), 64'h0);
        cyc(); set_op(ALU_NOP, 32'h0, 32'h0, 1'b0);

        // LD_HU with addr_ok three cycles late
        cyc(); set_op(ALU_LDHU, 32'h0000_0002, 32'h0, 1'b1);
        exp_q.push_back(32'h0000_8001);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cyc();
            data_addr_ok = (i == 3);
            @(negedge clk);
            check($sformatf("ldhu_req_%0d", i), 64'(data_req), 64'h1);
            check($sformatf("ldhu_addr_%0d", i), 64'(data_addr), 64'h0);
            check($sformatf("ldhu_pause_%0d", i), 64'(pause_request), 64'h1);
        end
        cyc(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h8001_0000;
        @(negedge clk);
        check("ldhu_wd_req", 64'(data_req), 64'h0);
        cyc(); data_data_ok = 1'b0; data_rdata = 32'h0;
        @(negedge clk);
        check("ldhu_done_pause", 64'(pause_request), 64'h0);
        check_sb("ldhu_result", out_reg_write_data);
        cyc(); set_op(ALU_NOP, 32'h0, 32'h0, 1'b0);

        // Flush in WAIT_DATA, drain, then a normal LD_W
        cyc(); set_op(ALU_LDW, 32'h0000_0100, 32'h0, 1'b1); data_addr_ok = 1'b1;
        @(negedge clk);
        check("fl_c0_req", 64'(data_req), 64'h1);
        cyc(); data_addr_ok = 1'b0; exception_flush = 1'b1;
        @(negedge clk);
        check("fl_c1_req", 64'(data_req), 64'h0);
        cyc(); exception_flush = 1'b0; set_op(ALU_NOP, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        check("drain_pause", 64'(pause_request), 64'h0);
        check("drain_req", 64'(data_req), 64'h0);
        cyc(); set_op(ALU_LDW, 32'h0000_0200, 32'h0, 1'b1);
        data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
        exp_q.push_back(32'h1122_3344);
        @(negedge clk);
        check("drain_hold_pause", 64'(pause_request), 64'h1);
        check("drain_hold_req", 64'(data_req), 64'h0);
        cyc(); data_data_ok = 1'b0; data_rdata = 32'h0; data_addr_ok = 1'b1;
        @(negedge clk);
        check("post_drain_req", 64'(data_req), 64'h1);
        check("post_drain_addr", 64'(data_addr), 64'h200);
        cyc(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1122_3344;
        cyc(); data_data_ok = 1'b0; data_rdata = 32'h0;
        @(negedge clk);
        check("post_drain_pause", 64'(pause_request), 64'h0);
        check_sb("post_drain_result", out_reg_write_data);
        cyc(); set_op(ALU_NOP, 32'h0, 32'h0, 1'b0);

        // LD_BU held in DONE by pause_wb
        cyc(); set_op(ALU_LDBU, 32'h0000_0001, 32'h0, 1'b1); data_addr_ok = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h0000_00AB);
        cyc(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0000_AB00;
        cyc(); data_data_ok = 1'b0; data_rdata = 32'h5555_5555; pause_wb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cyc();
            if (i == 3) pause_wb = 1'b0;
            @(negedge clk);
            check($sformatf("hold_pause_%0d", i), 64'(pause_request), 64'h0);
            check($sformatf("hold_req_%0d", i), 64'(data_req), 64'h0);
            check_sb($sformatf("hold_result_%0d", i), out_reg_write_data);
        end
        cyc(); set_op(ALU_LDH, 32'h0000_0004, 32'h0, 1'b1);
        @(negedge clk);
        check("idle_after_hold_req", 64'(data_req), 64'h1);
        check("idle_after_hold_pause", 64'(pause_request), 64'h1);

        // Reset mid-access
        cyc(); rst = 1'b1;
        cyc(); rst = 1'b0; set_op(ALU_NOP, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        check("rst_mid_req", 64'(data_req), 64'h0);
        check("rst_mid_pause", 64'(pause_request), 64'h0);
        check("sb_empty", 64'(exp_q.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
